// File: rtl/r_return_arbiter_if.sv
// ----------------------------------------------------------------------------
// r_return_arbiter_if
// Bundles the R-channel signals around r_return_arbiter: NUM_SRC packed
// incoming response streams, the single registered outgoing stream toward
// the ordering unit, and the sticky protocol-error flag.
//   master : drives src_* beats and out_ready, observes everything else
//   slave  : the arbiter itself (drives src_ready, out_*, proto_err)
// ----------------------------------------------------------------------------
interface r_return_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_ready;
    logic [NUM_SRC*ID_WIDTH-1:0]   src_id;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC*RESP_WIDTH-1:0] src_resp;
    logic [NUM_SRC-1:0]            src_last;

    logic                          out_valid;
    logic                          out_ready;
    logic [ID_WIDTH-1:0]           out_id;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [RESP_WIDTH-1:0]         out_resp;
    logic                          out_last;
    logic [SRC_W-1:0]              out_src;
    logic                          proto_err;

    modport master (
        output src_valid, src_id, src_data, src_resp, src_last, out_ready,
        input  src_ready, out_valid, out_id, out_data, out_resp, out_last,
               out_src, proto_err
    );

    modport slave (
        input  src_valid, src_id, src_data, src_resp, src_last, out_ready,
        output src_ready, out_valid, out_id, out_data, out_resp, out_last,
               out_src, proto_err
    );
endinterface

// File: rtl/r_return_arbiter.sv
// ----------------------------------------------------------------------------
// r_return_arbiter
// Round-robin arbiter sharing one R channel between NUM_SRC response buffers.
// A grant is locked from the first beat of a burst until its last beat (or a
// forced release after MAX_BEATS beats, which raises sticky proto_err). The
// winning beat is captured in a single registered output stage tagged with
// the source index.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : r_return_arbiter_if.slave (src_* in, src_ready out, out_* out,
//           out_ready in, proto_err out)
// ----------------------------------------------------------------------------
module r_return_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int MAX_BEATS  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    r_return_arbiter_if.slave   bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]        lock_src_q, lock_src_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    proto_err_q, proto_err_d;
    logic                    out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0]     out_id_q, out_id_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [RESP_WIDTH-1:0]   out_resp_q, out_resp_d;
    logic                    out_last_q, out_last_d;
    logic [SRC_W-1:0]        out_src_q, out_src_d;

    logic                    rr_found_s;
    logic [SRC_W-1:0]        rr_gnt_s;
    logic [SRC_W-1:0]        sel_src_s;
    logic                    sel_req_s;
    logic                    slot_free_s;
    logic [NUM_SRC-1:0]      src_ready_s;
    logic                    xfer_s;
    logic                    sel_last_s;

    // Successor index with explicit wrap so NUM_SRC need not be a power of two.
    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        logic [SRC_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = {SRC_W{1'b0}};
        end else begin
            nxt = idx + SRC_W'(1);
        end
        return nxt;
    endfunction

    // Round-robin search: first valid source starting at rr_ptr, wrapping.
    always_comb begin : rr_search
        int               cand;
        logic [SRC_W-1:0] cand_idx;
        cand       = 0;
        cand_idx   = {SRC_W{1'b0}};
        rr_found_s = 1'b0;
        rr_gnt_s   = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end else begin
                cand = cand;
            end
            cand_idx = SRC_W'(cand);
            if (!rr_found_s && bus.src_valid[cand_idx]) begin
                rr_found_s = 1'b1;
                rr_gnt_s   = cand_idx;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Grant selection: the locked source owns the channel during a burst,
    // even while it has no valid beat.
    always_comb begin
        if (state_q == ST_BURST) begin
            sel_src_s = lock_src_q;
            sel_req_s = 1'b1;
        end else begin
            sel_src_s = rr_gnt_s;
            sel_req_s = rr_found_s;
        end
    end

    assign slot_free_s = ~out_valid_q | bus.out_ready;

    // One-hot ready toward the granted source; held low while in reset.
    always_comb begin
        src_ready_s = {NUM_SRC{1'b0}};
        if (rst_n && sel_req_s && slot_free_s) begin
            src_ready_s[sel_src_s] = 1'b1;
        end else begin
            src_ready_s = {NUM_SRC{1'b0}};
        end
    end

    assign xfer_s     = bus.src_valid[sel_src_s] & src_ready_s[sel_src_s];
    assign sel_last_s = bus.src_last[sel_src_s];

    // Next-state: output stage load/drain plus burst lock FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_src_d  = lock_src_q;
        beat_cnt_d  = beat_cnt_q;
        proto_err_d = proto_err_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_id_d    = bus.src_id[int'(sel_src_s)*ID_WIDTH +: ID_WIDTH];
            out_data_d  = bus.src_data[int'(sel_src_s)*DATA_WIDTH +: DATA_WIDTH];
            out_resp_d  = bus.src_resp[int'(sel_src_s)*RESP_WIDTH +: RESP_WIDTH];
            out_last_d  = sel_last_s;
            out_src_d   = sel_src_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer_s && !sel_last_s) begin
                    state_d    = ST_BURST;
                    lock_src_d = sel_src_s;
                    beat_cnt_d = CNT_W'(1);
                end else if (xfer_s) begin
                    rr_ptr_d = next_idx(sel_src_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (xfer_s) begin
                    // A burst reaching MAX_BEATS without last is released as if
                    // it had ended, so one broken source cannot stall the rest.
                    if (sel_last_s || (beat_cnt_q == CNT_LIMIT)) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = next_idx(lock_src_q);
                        beat_cnt_d = {CNT_W{1'b0}};
                        if (!sel_last_s) begin
                            proto_err_d = 1'b1;
                        end else begin
                            proto_err_d = proto_err_q;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output-stage registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {SRC_W{1'b0}};
            lock_src_q  <= {SRC_W{1'b0}};
            beat_cnt_q  <= {CNT_W{1'b0}};
            proto_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= {ID_WIDTH{1'b0}};
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_resp_q  <= {RESP_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_src_q   <= {SRC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_src_q  <= lock_src_d;
            beat_cnt_q  <= beat_cnt_d;
            proto_err_q <= proto_err_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_resp_q  <= out_resp_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.src_ready = src_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_resp  = out_resp_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_r_return_arbiter.sv
// ----------------------------------------------------------------------------
// tb_r_return_arbiter
// Self-checking bench for r_return_arbiter (NUM_SRC=4, MAX_BEATS=4). A
// behavioural model tracks the owner of the channel, the round-robin start
// point and the pending output beat; a negedge process compares the DUT to
// it every cycle. Directed scenarios pin the model with literal values, then
// a randomized phase runs against the model alone.
// ----------------------------------------------------------------------------
module tb_r_return_arbiter;
    localparam int NS  = 4;
    localparam int IDW = 4;
    localparam int DW  = 64;
    localparam int RW  = 2;
    localparam int MB  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    r_return_arbiter_if #(.NUM_SRC(NS), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();

    r_return_arbiter #(
        .NUM_SRC(NS), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .MAX_BEATS(MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: owner of a burst in progress (-1 = free), round-robin start,
    // beats taken in the current burst, sticky error, pending output beat.
    int              m_rr;
    int              m_lock;
    int              m_cnt;
    bit              m_err;
    bit              m_ov;
    logic [IDW-1:0]  m_id;
    logic [DW-1:0]   m_data;
    logic [RW-1:0]   m_resp;
    bit              m_last;
    int              m_src;

    // Beats seen leaving the output stage.
    int log_src[$];
    int log_id[$];
    bit log_last[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int s;
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < NS; k++) begin
            s = (m_rr + k) % NS;
            if (bus.src_valid[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] model_ready();
        logic [NS-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (rst_n && g >= 0 && (!m_ov || bus.out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        int g;
        bit xfer;
        if (!rst_n) begin
            m_rr = 0; m_lock = -1; m_cnt = 0; m_err = 0; m_ov = 0;
            m_id = '0; m_data = '0; m_resp = '0; m_last = 0; m_src = 0;
        end else begin
            if (m_ov && bus.out_ready) begin
                log_src.push_back(m_src);
                log_id.push_back(int'(m_id));
                log_last.push_back(m_last);
            end
            g = model_grant();
            xfer = (g >= 0) && (!m_ov || bus.out_ready) && bus.src_valid[g];
            if (xfer) begin
                m_ov   = 1;
                m_id   = bus.src_id[g*IDW +: IDW];
                m_data = bus.src_data[g*DW +: DW];
                m_resp = bus.src_resp[g*RW +: RW];
                m_last = bus.src_last[g];
                m_src  = g;
                if (m_lock < 0) begin
                    if (bus.src_last[g]) m_rr = (g + 1) % NS;
                    else begin m_lock = g; m_cnt = 1; end
                end else begin
                    m_cnt++;
                    if (bus.src_last[g] || m_cnt == MB) begin
                        if (!bus.src_last[g]) m_err = 1;
                        m_lock = -1;
                        m_rr = (g + 1) % NS;
                        m_cnt = 0;
                    end
                end
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("src_ready", 64'(bus.src_ready), 64'(model_ready()));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_id",    64'(bus.out_id),    64'(m_id));
        chk("out_data",  64'(bus.out_data),  64'(m_data));
        chk("out_resp",  64'(bus.out_resp),  64'(m_resp));
        chk("out_last",  64'(bus.out_last),  64'(m_last));
        chk("out_src",   64'(bus.out_src),   64'(m_src));
        chk("proto_err", 64'(bus.proto_err), 64'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int s, input bit v, input int id, input bit last);
        bus.src_valid[s] = v;
        bus.src_last[s]  = last;
        bus.src_id[s*IDW +: IDW] = IDW'(id);
        bus.src_data[s*DW +: DW] = {$urandom, $urandom};
        bus.src_resp[s*RW +: RW] = RW'($urandom_range(0, 3));
    endtask

    task automatic clear_log();
        log_src.delete();
        log_id.delete();
        log_last.delete();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.src_valid = '0; bus.src_last = '0; bus.src_id = '0;
        bus.src_data = '0; bus.src_resp = '0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: nothing offered, nothing produced.
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("idle_valid", 64'(bus.out_valid), 64'(0));
            chk("idle_ready", 64'(bus.src_ready), 64'(0));
            chk("idle_err",   64'(bus.proto_err), 64'(0));
            tick();
        end

        // Single-beat bursts from all sources: strict rotation, 1 beat/cycle.
        clear_log();
        bus.out_ready = 1'b1;
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, s, 1'b1);
        repeat (8) tick();
        for (int s = 0; s < NS; s++) set_src(s, 1'b0, 0, 1'b0);
        repeat (2) tick();
        chk("rr_count", 64'(log_src.size()), 64'(8));
        for (int k = 0; k < 8 && k < log_src.size(); k++) begin
            chk("rr_src", 64'(log_src[k]), 64'(k % NS));
            chk("rr_id",  64'(log_id[k]),  64'(k % NS));
        end

        // Src1 4-beat burst locks out src2 until its last beat.
        clear_log();
        set_src(2, 1'b1, 2, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_src(1, 1'b1, 5, b == 3);
            #2;
            chk("burst_rdy", 64'(bus.src_ready), 64'(4'b0010));
            tick();
        end
        set_src(1, 1'b0, 0, 1'b0);
        repeat (2) tick();
        set_src(2, 1'b0, 0, 1'b0);
        repeat (2) tick();
        chk("burst_count", 64'(log_src.size()), 64'(6));
        for (int k = 0; k < 4 && k < log_src.size(); k++) begin
            chk("burst_src",  64'(log_src[k]),  64'(1));
            chk("burst_id",   64'(log_id[k]),   64'(5));
            chk("burst_last", 64'(log_last[k]), 64'(k == 3));
        end
        if (log_src.size() > 4) chk("after_burst_src", 64'(log_src[4]), 64'(2));

        // Back-pressure: held beat stays stable, no ready, then no-bubble reload.
        bus.out_ready = 1'b0;
        set_src(0, 1'b1, 7, 1'b1);
        #2;
        chk("bp_first_rdy", 64'(bus.src_ready), 64'(4'b0001));
        tick();
        set_src(0, 1'b0, 0, 1'b0);
        set_src(3, 1'b1, 9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_id",    64'(bus.out_id),    64'(7));
            chk("bp_src",   64'(bus.out_src),   64'(0));
            chk("bp_rdy",   64'(bus.src_ready), 64'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        #2;
        chk("bp_release_rdy", 64'(bus.src_ready), 64'(4'b1000));
        tick();
        set_src(3, 1'b0, 0, 1'b0);
        #2;
        chk("bp_next_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_next_id",    64'(bus.out_id),    64'(9));
        chk("bp_next_src",   64'(bus.out_src),   64'(3));
        tick();
        #2;
        chk("bp_drained", 64'(bus.out_valid), 64'(0));
        tick();

        // Runaway burst: forced release after MAX_BEATS, sticky error, src1 next.
        clear_log();
        set_src(0, 1'b1, 1, 1'b0);
        set_src(1, 1'b1, 3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("perr_flag", 64'(bus.proto_err), 64'(k >= 4));
            tick();
        end
        set_src(0, 1'b0, 0, 1'b0);
        set_src(1, 1'b0, 0, 1'b0);
        repeat (2) tick();
        chk("perr_count", 64'(log_src.size()), 64'(5));
        for (int k = 0; k < 5 && k < log_src.size(); k++) begin
            chk("perr_src", 64'(log_src[k]), 64'((k == 4) ? 1 : 0));
        end
        if (log_last.size() > 3) chk("perr_beat4_last", 64'(log_last[3]), 64'(0));

        // Asynchronous reset during beat 2 of a 3-beat burst.
        set_src(2, 1'b1, 6, 1'b0);
        tick();
        #2;
        chk("mid_valid_before", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_ready", 64'(bus.src_ready), 64'(0));
        chk("rst_err",   64'(bus.proto_err), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
        set_src(0, 1'b1, 8, 1'b1);
        #2;
        chk("post_rst_rdy", 64'(bus.src_ready), 64'(4'b0001));
        tick();
        set_src(0, 1'b0, 0, 1'b0);
        set_src(2, 1'b0, 0, 1'b0);
        repeat (2) tick();
        chk("post_rst_count", 64'(log_src.size()), 64'(1));
        if (log_src.size() > 0) begin
            chk("post_rst_src", 64'(log_src[0]), 64'(0));
            chk("post_rst_id",  64'(log_id[0]),  64'(8));
        end

        // Randomized traffic checked by the per-cycle compare process.
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < NS; s++) begin
                set_src(s, $urandom_range(0, 9) < 6, int'($urandom_range(0, 15)),
                        $urandom_range(0, 9) < 4);
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus.src_valid = '0;
        bus.out_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
